// File: rtl/rm_c5_report_collector_if.sv
// Head-of-queue record handshake between the report collector and the host monitor.
interface rm_c5_report_collector_if #(
    parameter int unsigned NUM_REPORTS = 36,
    parameter int unsigned CNT_W       = 32
);
    logic                   rec_valid;
    logic                   rec_ready;
    logic [CNT_W-1:0]       rec_cycle;
    logic [NUM_REPORTS-1:0] rec_reports;

    modport master (output rec_valid, output rec_cycle, output rec_reports, input rec_ready);
    modport slave  (input rec_valid, input rec_cycle, input rec_reports, output rec_ready);
endinterface

// File: rtl/rm_c5_report_collector.sv
// Timestamps non-zero cluster-5 report vectors and buffers them in a show-ahead FIFO.
// Pushes are never stalled; a push into a full FIFO without a pop is dropped and counted.
module rm_c5_report_collector #(
    parameter int unsigned NUM_REPORTS = 36,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [NUM_REPORTS-1:0]     report_in,
    rm_c5_report_collector_if.master   rec,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic                       report_any
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CNT_W-1:0]       cyc;
    logic [CNT_W-1:0]       cyc_mem [DEPTH];
    logic [NUM_REPORTS-1:0] rep_mem [DEPTH];

    logic empty;
    logic full;
    logic push_req;
    logic pop;
    logic push;
    logic drop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req = run && (|report_in);
    assign pop      = !empty && rec.rec_ready;
    // A pop on the same edge frees the head slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign fifo_count      = wr_ptr - rd_ptr;
    assign rec.rec_valid   = !empty;
    assign rec.rec_cycle   = empty ? '0 : cyc_mem[rd_ptr[AW-1:0]];
    assign rec.rec_reports = empty ? '0 : rep_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cyc        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            report_any <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (run) begin
                cyc        <= cyc + 1'b1;
                report_any <= |report_in;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // Storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            cyc_mem[wr_ptr[AW-1:0]] <= cyc;
            rep_mem[wr_ptr[AW-1:0]] <= report_in;
        end
    end
endmodule
